fu_alu_pipe: RTL and testbench
==============================

Name: fu_alu_pipe

Overview:
Parametrised successor to the single-cycle integer ALU functional unit. Accepts one issued instruction per cycle from the reservation station over a valid/ready handshake. Computes the ALU result, branch compare and branch target through a LAT-deep pipeline with full backpressure and flush. Delivers a tagged result to the CDB/writeback arbiter.

Parameters:
XLEN, 32, datapath width.
LAT, 2, pipeline depth in cycles from accept to out_valid; legal range 1..4.
TAG_W, 6, physical destination register tag width.
ROB_W, 5, ROB index width.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  issue request from reservation station
in_ready  out  1  FU can accept this cycle
in_aluop  in  3  ALU operation
in_cmpop  in  3  compare operation
in_op1_sel  in  2  operand A select
in_op2_sel  in  2  operand B select
in_rs1_v  in  XLEN  rs1 physical register value
in_rs2_v  in  XLEN  rs2 physical register value
in_imm  in  XLEN  sign-extended immediate
in_pc  in  XLEN  instruction PC
in_pd  in  TAG_W  destination physical tag
in_rob_id  in  ROB_W  ROB index
flush  in  1  mispredict squash, kills all in-flight ops
out_valid  out  1  result available
out_ready  in  1  writeback arbiter accepts result
out_result  out  XLEN  ALU result
out_br_en  out  1  compare outcome
out_br_target  out  XLEN  in_pc + in_imm (mod 2^XLEN)
out_pd  out  TAG_W  tag of result
out_rob_id  out  ROB_W  ROB index of result
perf_issued  out  32  accepted-op counter (optional feature)
perf_stall  out  32  backpressure-cycle counter (optional feature)

Behaviour:
- Operand A: op1_sel 00=rs1_v, 01=imm, 11=pc, 10=0. Operand B: op2_sel 00=rs2_v, 01=0, 11=imm, 10=0.
- ALU op: 000 add, 001 sll, 010 sra, 011 sub, 100 xor, 101 srl, 110 or, 111 and. Shifts use B[4:0]; sra is arithmetic. Results wrap mod 2^XLEN.
- Compare always uses rs1_v/rs2_v: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu; 010/011 give 0.
- All of result, br_en and target are computed in stage 0. Stages 1..LAT-1 carry data; each stage has a valid bit.
- Accept: in_valid && in_ready at posedge. First out_valid LAT cycles later when out_ready is held high.
- Stage k advances when stage k+1 is empty or advancing. The last stage advances when out_ready is high.
- in_ready = !stage0_valid || stage0_advancing. Combinational from out_ready is permitted.
- Full throughput of one op/cycle under continuous out_ready. No bubble insertion, no reordering.
- Backpressure: out_ready low holds out_* stable with out_valid high. Upstream stages fill, then in_ready drops. Nothing is lost or duplicated.
- Flush: all valid bits clear on that posedge. An input offered in the flush cycle is dropped, even if in_ready is high. out_valid is 0 the following cycle. A result handshaked in the flush cycle counts as delivered.
- Reset: all valid bits 0; out_valid=0, out_result=0, out_br_en=0, out_br_target=0, out_pd=0, out_rob_id=0; perf counters 0.
- Reset asserted mid-stream discards all in-flight ops. in_ready=1 the first cycle after rst deasserts.
- Payload registers update only when their stage loads. Valid bits gate all use.

Optional Feature:
FU_ALU_PIPE_PERF_EN
- Defined: perf_issued increments on each accepted op. perf_stall increments each cycle with out_valid && !out_ready. Both wrap at 2^32 and are cleared only by rst; flush does not clear them.
- Undefined: the counters are not synthesised and perf_issued/perf_stall are tied to 0.

Test Plan:
- LAT=2, add, op1=00, op2=00, rs1=5, rs2=7, pd=3, out_ready=1 -> out_valid exactly 2 cycles after accept; result=12, pd=3.
- Branch, cmpop=100, rs1=0xFFFFFFFF, rs2=1, op1=11, op2=11, pc=0x1000, imm=0xFFFFFFF0 -> br_en=1, br_target=0x00000FF0; same with cmpop=110 -> br_en=0.
- Issue 4 back-to-back ops, out_ready low for 5 cycles -> in_ready drops once LAT stages are full; out_* held stable; all 4 results drain in issue order after release.
- Issue 2 ops, assert flush 1 cycle later with in_valid=1 -> no out_valid for any of the 3 ops; next op issued after the flush completes normally.
- sra, rs1=0x80000000, op2=11, imm=4 -> 0xF8000000; srl same operands -> 0x08000000; sub 0-1 -> 0xFFFFFFFF.
- With FU_ALU_PIPE_PERF_EN, 3 ops accepted and 2 stall cycles -> perf_issued=3, perf_stall=2; assert rst -> both 0.

Source files
------------

// File: rtl/fu_alu_pipe.sv
// Pipelined integer ALU functional unit: LAT-deep valid/ready pipeline with flush.
// Optional perf counters are built when FU_ALU_PIPE_PERF_EN is defined.
module fu_alu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_aluop,
  input  logic [2:0]       in_cmpop,
  input  logic [1:0]       in_op1_sel,
  input  logic [1:0]       in_op2_sel,
  input  logic [XLEN-1:0]  in_rs1_v,
  input  logic [XLEN-1:0]  in_rs2_v,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_pd,
  input  logic [ROB_W-1:0] in_rob_id,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_br_en,
  output logic [XLEN-1:0]  out_br_target,
  output logic [TAG_W-1:0] out_pd,
  output logic [ROB_W-1:0] out_rob_id,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
);

  logic [LAT-1:0]   vld_q, vld_d;
  logic [LAT-1:0]   br_q, br_d;
  logic [XLEN-1:0]  res_q [LAT];
  logic [XLEN-1:0]  res_d [LAT];
  logic [XLEN-1:0]  tgt_q [LAT];
  logic [XLEN-1:0]  tgt_d [LAT];
  logic [TAG_W-1:0] pd_q  [LAT];
  logic [TAG_W-1:0] pd_d  [LAT];
  logic [ROB_W-1:0] rob_q [LAT];
  logic [ROB_W-1:0] rob_d [LAT];

  logic [LAT-1:0]   room;
  logic             in_fire;
  logic [XLEN-1:0]  opa, opb, alu_res, tgt_c;
  logic             br_c;

  // Stage-0 operand select, ALU, compare and branch target
  always_comb begin
    opa = '0;
    opb = '0;
    case (in_op1_sel)
      2'b00:   opa = in_rs1_v;
      2'b01:   opa = in_imm;
      2'b11:   opa = in_pc;
      default: opa = '0;
    endcase
    case (in_op2_sel)
      2'b00:   opb = in_rs2_v;
      2'b11:   opb = in_imm;
      default: opb = '0;
    endcase
    case (in_aluop)
      3'b000:  alu_res = opa + opb;
      3'b001:  alu_res = opa << opb[4:0];
      3'b010:  alu_res = XLEN'($signed(opa) >>> opb[4:0]);
      3'b011:  alu_res = opa - opb;
      3'b100:  alu_res = opa ^ opb;
      3'b101:  alu_res = opa >> opb[4:0];
      3'b110:  alu_res = opa | opb;
      default: alu_res = opa & opb;
    endcase
    case (in_cmpop)
      3'b000:  br_c = (in_rs1_v == in_rs2_v);
      3'b001:  br_c = (in_rs1_v != in_rs2_v);
      3'b100:  br_c = ($signed(in_rs1_v) <  $signed(in_rs2_v));
      3'b101:  br_c = ($signed(in_rs1_v) >= $signed(in_rs2_v));
      3'b110:  br_c = (in_rs1_v <  in_rs2_v);
      3'b111:  br_c = (in_rs1_v >= in_rs2_v);
      default: br_c = 1'b0;
    endcase
    tgt_c = in_pc + in_imm;
  end

  // room[k]: stage k may load this cycle (out_ready or any empty slot at or after k)
  always_comb begin
    logic space;
    room  = '0;
    space = out_ready;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      space   = space | ~vld_q[k];
      room[k] = space;
    end
  end

  assign in_ready = room[0];
  assign in_fire  = in_valid && room[0] && !flush;

  // Valid propagation and payload loads; payload only moves when a stage loads
  always_comb begin
    vld_d = vld_q;
    br_d  = br_q;
    res_d = res_q;
    tgt_d = tgt_q;
    pd_d  = pd_q;
    rob_d = rob_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (room[0]) vld_d[0] = in_valid;
      for (int k = 1; k < int'(LAT); k++) begin
        if (room[k]) vld_d[k] = vld_q[k-1];
      end
    end
    if (in_fire) begin
      res_d[0] = alu_res;
      br_d[0]  = br_c;
      tgt_d[0] = tgt_c;
      pd_d[0]  = in_pd;
      rob_d[0] = in_rob_id;
    end
    for (int k = 1; k < int'(LAT); k++) begin
      if (room[k] && vld_q[k-1] && !flush) begin
        res_d[k] = res_q[k-1];
        br_d[k]  = br_q[k-1];
        tgt_d[k] = tgt_q[k-1];
        pd_d[k]  = pd_q[k-1];
        rob_d[k] = rob_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      br_q  <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        res_q[k] <= '0;
        tgt_q[k] <= '0;
        pd_q[k]  <= '0;
        rob_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      br_q  <= br_d;
      res_q <= res_d;
      tgt_q <= tgt_d;
      pd_q  <= pd_d;
      rob_q <= rob_d;
    end
  end

  assign out_valid     = vld_q[LAT-1];
  assign out_result    = res_q[LAT-1];
  assign out_br_en     = br_q[LAT-1];
  assign out_br_target = tgt_q[LAT-1];
  assign out_pd        = pd_q[LAT-1];
  assign out_rob_id    = rob_q[LAT-1];

`ifdef FU_ALU_PIPE_PERF_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  // Counters wrap naturally; only reset clears them
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (in_fire)                 issued_d = issued_q + 32'd1;
    if (out_valid && !out_ready) stall_d  = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed bench for fu_alu_pipe: vector table through a scoreboard, plus
// latency, backpressure, flush, reset and perf-counter sequences.
module tb_fu_alu_pipe;
  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = 2;
  localparam int NV = 12;

  typedef struct {
    logic [2:0]  aluop;
    logic [2:0]  cmpop;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [5:0]  pd;
    logic [4:0]  rob;
    logic [31:0] res;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready, out_br_en;
  logic [31:0] out_result, out_br_target, perf_issued, perf_stall;
  logic [5:0] out_pd;
  logic [4:0] out_rob_id;
  vec_t cur;
  vec_t vecs [NV];
  vec_t expq [$];

  int checks = 0;
  int errors = 0;
  logic stall_prev;
  logic [31:0] held_res, held_tgt;
  logic        held_br;

  always #5 clk = ~clk;

  fu_alu_pipe #(.XLEN(XLEN), .LAT(LAT), .TAG_W(6), .ROB_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(cur.aluop), .in_cmpop(cur.cmpop), .in_op1_sel(cur.s1), .in_op2_sel(cur.s2),
    .in_rs1_v(cur.rs1), .in_rs2_v(cur.rs2), .in_imm(cur.imm), .in_pc(cur.pc),
    .in_pd(cur.pd), .in_rob_id(cur.rob), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_br_en(out_br_en), .out_br_target(out_br_target), .out_pd(out_pd),
    .out_rob_id(out_rob_id), .perf_issued(perf_issued), .perf_stall(perf_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] a, input logic [2:0] c, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] pd,
                              input logic [4:0] rob, input logic [31:0] res, input logic br,
                              input logic [31:0] tgt);
    vec_t v;
    v.aluop = a; v.cmpop = c; v.s1 = s1; v.s2 = s2; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.pc = pc; v.pd = pd; v.rob = rob; v.res = res; v.br = br; v.tgt = tgt;
    return v;
  endfunction

  // Scoreboard: deliveries checked in order, accepts recorded, stalls checked for hold
  always @(negedge clk) begin
    vec_t e;
    if (rst) begin
      expq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", out_result, held_res);
        chk("hold_br_en", 32'(out_br_en), 32'(held_br));
        chk("hold_target", out_br_target, held_tgt);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got result 0x%08h pd %0d expected no output", out_result, out_pd);
        end else begin
          e = expq.pop_front();
          chk("result", out_result, e.res);
          chk("br_en", 32'(out_br_en), 32'(e.br));
          chk("target", out_br_target, e.tgt);
          chk("pd", 32'(out_pd), 32'(e.pd));
          chk("rob_id", 32'(out_rob_id), 32'(e.rob));
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      held_res = out_result;
      held_br  = out_br_en;
      held_tgt = out_br_target;
      if (flush) expq.delete();
      else if (in_valid && in_ready) expq.push_back(cur);
    end
  end

  // Present vecs[first..first+n-1] in order, holding each until accepted
  task automatic issue_n(input int first, input int n);
    int i = 0;
    int budget = 0;
    logic acc;
    while (i < n) begin
      cur = vecs[(first + i) % NV];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      budget++;
      if (budget > 200) begin
        chk("issue_timeout", 32'(i), 32'(n));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = mk(3'b000, 3'b000, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 6'd3, 5'd1, 32'd12, 1'b0, 32'd0);
    vecs[1]  = mk(3'b000, 3'b100, 2'b11, 2'b11, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h1000, 6'd4, 5'd2, 32'h00000FF0, 1'b1, 32'h00000FF0);
    vecs[2]  = mk(3'b000, 3'b110, 2'b11, 2'b11, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h1000, 6'd5, 5'd3, 32'h00000FF0, 1'b0, 32'h00000FF0);
    vecs[3]  = mk(3'b010, 3'b001, 2'b00, 2'b11, 32'h80000000, 32'd0, 32'd4, 32'd0, 6'd6, 5'd4, 32'hF8000000, 1'b1, 32'd4);
    vecs[4]  = mk(3'b101, 3'b001, 2'b00, 2'b11, 32'h80000000, 32'd0, 32'd4, 32'd0, 6'd7, 5'd5, 32'h08000000, 1'b1, 32'd4);
    vecs[5]  = mk(3'b011, 3'b101, 2'b10, 2'b00, 32'd3, 32'd1, 32'd0, 32'h20, 6'd8, 5'd6, 32'hFFFFFFFF, 1'b1, 32'h20);
    vecs[6]  = mk(3'b001, 3'b111, 2'b00, 2'b00, 32'd1, 32'd33, 32'd0, 32'd0, 6'd9, 5'd7, 32'd2, 1'b0, 32'd0);
    vecs[7]  = mk(3'b100, 3'b010, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 6'd10, 5'd8, 32'h0FF0, 1'b0, 32'd0);
    vecs[8]  = mk(3'b110, 3'b011, 2'b00, 2'b00, 32'hF0, 32'h0F, 32'd0, 32'd0, 6'd11, 5'd9, 32'hFF, 1'b0, 32'd0);
    vecs[9]  = mk(3'b111, 3'b000, 2'b01, 2'b00, 32'h0F, 32'h0F, 32'hFF, 32'h100, 6'd12, 5'd10, 32'h0F, 1'b1, 32'h1FF);
    vecs[10] = mk(3'b000, 3'b100, 2'b11, 2'b01, 32'd1, 32'hFFFFFFFF, 32'h10, 32'h40, 6'd13, 5'd11, 32'h40, 1'b0, 32'h50);
    vecs[11] = mk(3'b000, 3'b000, 2'b00, 2'b10, 32'd9, 32'd9, 32'd0, 32'd0, 6'd63, 5'd31, 32'd9, 1'b1, 32'd0);

    cur = vecs[0];
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_br_en", 32'(out_br_en), 32'd0);
    chk("rst_target", out_br_target, 32'd0);
    chk("rst_pd", 32'(out_pd), 32'd0);
    chk("rst_rob_id", 32'(out_rob_id), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_perf_issued", perf_issued, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);

    // Latency: n counts edges after the accept edge until out_valid shows,
    // so delivery happens on the LAT-th edge after accept
    cur = vecs[0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(LAT - 1));
    chk("lat_result", out_result, 32'd12);
    chk("lat_pd", 32'(out_pd), 32'd3);
    drain();

    // Whole table back-to-back at full throughput
    n = $time;
    issue_n(0, NV);
    chk("throughput_cycles", 32'(($time - n) / 10), 32'(NV));
    drain();

    // Backpressure: 4 ops with out_ready low for 5 cycles
    out_ready = 1'b0;
    fork
      issue_n(3, 4);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_inflight", 32'(expq.size()), 32'(LAT));
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head_result", out_result, 32'hF8000000);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with a third op offered in the flush cycle
    out_ready = 1'b0;
    issue_n(6, 2);
    cur = vecs[8];
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("flush_no_output", 32'(n), 32'd0);
    issue_n(9, 1);
    drain();

    // Mid-stream reset discards in-flight work
    out_ready = 1'b0;
    issue_n(10, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("midrst_no_output", 32'(n), 32'd0);

    // Perf counters: 3 accepted ops, exactly 2 stall cycles
    do_reset();
    out_ready = 1'b1;
    fork
      issue_n(0, 3);
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
`ifdef FU_ALU_PIPE_PERF_EN
    chk("perf_issued", perf_issued, 32'd3);
    chk("perf_stall", perf_stall, 32'd2);
`else
    chk("perf_issued_off", perf_issued, 32'd0);
    chk("perf_stall_off", perf_stall, 32'd0);
`endif
    do_reset();
    chk("perf_issued_rst", perf_issued, 32'd0);
    chk("perf_stall_rst", perf_stall, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
